// File: rtl/cpu_defs.sv
// Shared encodings for the multi-cycle CPU: opcodes, controller states and the
// select codes seen by the datapath muxes and the ALU control block.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/memory handshake in, mux selects and
// enables out. master is the controller side, slave the datapath side.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state_out;

    modport master (
        input  opcode, mem_ready,
        output alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_src,
               i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, illegal_op, state_out
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_src,
               i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, illegal_op, state_out
    );

endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle datapath: one state per datapath cycle,
// outputs decoded from the registered state (mem_ready gates FETCH writes).
module multicycle_control
    import cpu_defs::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t     state, state_nxt;
    logic [5:0] op_q;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                op_q <= bus.opcode;
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            // lw/sw split uses the opcode latched in DECODE, not the live IR
            S_MEMADR: state_nxt = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !is_legal_op(bus.opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
        // Reset masks every strobe so an aborted instruction cannot write
        if (!rst_n)
            ctrl = '0;
    end

    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state_out     = rst_n ? 4'(state) : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table of inputs and
// expected state/outputs, plus bounded instruction-latency sequences.
module tb_multicycle_control;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    // {a, b[1:0], op[1:0], pw, pwc, src[1:0], iord, mr, mw, irw, m2r, rdst, rw, ill}
    localparam logic [16:0] E_ZERO   = 17'b0_00_00_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_FWAIT  = 17'b0_01_00_0_0_00_0_1_0_0_0_0_0_0;
    localparam logic [16:0] E_FRDY   = 17'b0_01_00_1_0_00_0_1_0_1_0_0_0_0;
    localparam logic [16:0] E_DEC    = 17'b0_11_00_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_DECILL = 17'b0_11_00_0_0_00_0_0_0_0_0_0_0_1;
    localparam logic [16:0] E_MADR   = 17'b1_10_00_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_MRD    = 17'b0_00_00_0_0_00_1_1_0_0_0_0_0_0;
    localparam logic [16:0] E_MWB    = 17'b0_00_00_0_0_00_0_0_0_0_1_0_1_0;
    localparam logic [16:0] E_MWR    = 17'b0_00_00_0_0_00_1_0_1_0_0_0_0_0;
    localparam logic [16:0] E_EXEC   = 17'b1_00_10_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_ALUWB  = 17'b0_00_00_0_0_00_0_0_0_0_0_1_1_0;
    localparam logic [16:0] E_BR     = 17'b1_00_01_0_1_01_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_AEX    = 17'b1_10_00_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [16:0] E_AWB    = 17'b0_00_00_0_0_00_0_0_0_0_0_0_1_0;
    localparam logic [16:0] E_JMP    = 17'b0_00_00_1_0_10_0_0_0_0_0_0_0_0;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] act;
    assign act = {bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_write,
                  bus.pc_write_cond, bus.pc_src, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.illegal_op};

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic m,
                       input logic [3:0] s, input logic [16:0] e);
        vecs.push_back('{r, o, m, s, e});
    endtask

    // Starts from FETCH with mem_ready=1; counts edges until FETCH returns.
    task automatic latency(input string name, input logic [5:0] op, input int exp);
        int cyc;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = op;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (bus.state_out != 4'd0 && cyc < 20);
        check(name, 0, cyc, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b1;

        // reset held 3 cycles with mem_ready=1
        repeat (3) add(0, LW, 1, 0, E_ZERO);
        // lw, no stalls; opcode changes under MEMADR must be ignored
        add(1, LW, 1, 0, E_FRDY);
        add(1, LW, 1, 1, E_DEC);
        add(1, SW, 1, 2, E_MADR);
        add(1, SW, 1, 3, E_MRD);
        add(1, LW, 1, 4, E_MWB);
        // lw with 2 stalls in FETCH and 2 in MEMRD: 9 cycles
        add(1, LW, 0, 0, E_FWAIT);
        add(1, LW, 0, 0, E_FWAIT);
        add(1, LW, 1, 0, E_FRDY);
        add(1, LW, 1, 1, E_DEC);
        add(1, LW, 1, 2, E_MADR);
        add(1, LW, 0, 3, E_MRD);
        add(1, LW, 0, 3, E_MRD);
        add(1, LW, 1, 3, E_MRD);
        add(1, LW, 0, 4, E_MWB);
        // R-type then beq
        add(1, RT, 1, 0, E_FRDY);
        add(1, RT, 1, 1, E_DEC);
        add(1, RT, 1, 6, E_EXEC);
        add(1, RT, 1, 7, E_ALUWB);
        add(1, BEQ, 1, 0, E_FRDY);
        add(1, BEQ, 1, 1, E_DEC);
        add(1, BEQ, 1, 8, E_BR);
        // addi, j, illegal
        add(1, ADDI, 1, 0, E_FRDY);
        add(1, ADDI, 1, 1, E_DEC);
        add(1, ADDI, 1, 9, E_AEX);
        add(1, ADDI, 1, 10, E_AWB);
        add(1, JMP, 1, 0, E_FRDY);
        add(1, JMP, 1, 1, E_DEC);
        add(1, JMP, 1, 11, E_JMP);
        add(1, BAD, 1, 0, E_FRDY);
        add(1, BAD, 1, 1, E_DECILL);
        // sw stalled in MEMWR, then reset aborts it
        add(1, SW, 1, 0, E_FRDY);
        add(1, SW, 1, 1, E_DEC);
        add(1, LW, 1, 2, E_MADR);
        add(1, SW, 0, 5, E_MWR);
        add(1, SW, 0, 5, E_MWR);
        add(0, SW, 0, 0, E_ZERO);
        add(1, SW, 0, 0, E_FWAIT);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            bus.opcode = vecs[i].op;
            bus.mem_ready = vecs[i].mr;
            #1;
            check("state", i, 32'(bus.state_out), 32'(vecs[i].st));
            check("outputs", i, 32'(act), 32'(vecs[i].ex));
            if (vecs[i].st != 4'd0)
                check("one_write", i,
                      32'(int'(bus.reg_write) + int'(bus.mem_write) + int'(bus.pc_write) <= 1),
                      32'd1);
        end

        latency("lat_lw", LW, 5);
        latency("lat_sw", SW, 4);
        latency("lat_rtype", RT, 4);
        latency("lat_addi", ADDI, 4);
        latency("lat_beq", BEQ, 3);
        latency("lat_j", JMP, 3);
        latency("lat_illegal", BAD, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
